arb_requester: RTL and testbench
================================

ARB_REQUESTER -- requirements
Module: arb_requester

Interface
REQ-001 Parameter DATA_W, default 8, width of each queued data word.
REQ-002 Parameter DEPTH, default 4, FIFO depth in words; power of two, at least 2.
REQ-003 Parameter BURST_LEN, default 2, maximum words sent per grant.
REQ-004 Parameter TIMEOUT, default 15, grant-wait limit in cycles; used only under REQ_TIMEOUT_EN.
REQ-005 clk  input  1  single clock, rising edge.
REQ-006 rst  input  1  asynchronous, active-low reset.
REQ-007 push  input  1  enqueue push_data this cycle.
REQ-008 push_data  input  DATA_W  word to enqueue.
REQ-009 full  output  1  FIFO holds DEPTH words.
REQ-010 count  output  log2(DEPTH)+1  current FIFO occupancy.
REQ-011 req  output  1  request line to the 3-way arbiter (one of req_0/req_1/req_2).
REQ-012 gnt  input  1  matching grant from the arbiter.
REQ-013 bus_valid  output  1  bus_data carries a word this cycle.
REQ-014 bus_data  output  DATA_W  word driven onto the shared bus.
REQ-015 busy  output  1  FSM not in IDLE.
REQ-016 timeout  output  1  one-cycle pulse on grant-wait abort; exists only under REQ_TIMEOUT_EN.

Function
REQ-017 States: IDLE, REQ, XFER, HOLD; all outputs are registered.
REQ-018 IDLE -> REQ when count is nonzero; req stays 0 in IDLE.
REQ-019 In REQ, req=1; gnt sampled at 1 -> XFER next cycle; gnt at 0 -> stay in REQ.
REQ-020 In XFER, req=1; each cycle gnt=1 pops one word and drives it on bus_data with bus_valid=1 in the same cycle.
REQ-021 XFER ends after BURST_LEN pops or when the FIFO becomes empty, whichever comes first; the next state is HOLD.
REQ-022 gnt=0 while in XFER: no pop, bus_valid=0, next state REQ (FIFO nonempty) or IDLE (FIFO empty).
REQ-023 HOLD lasts exactly one cycle with req=0, so the arbiter can rotate; then IDLE.
REQ-024 A push when full is dropped; FIFO contents and count are unchanged.
REQ-025 A push and a pop in the same cycle are both performed; count is unchanged.
REQ-026 Pointers wrap modulo DEPTH; words leave the FIFO in the order they were pushed.
REQ-027 bus_data holds its last value when bus_valid=0; consumers ignore it.
REQ-028 full = (count==DEPTH), decoded from the registered count.

Reset
REQ-029 rst=0 forces, immediately, state=IDLE, FIFO pointers=0, count=0, req=0, bus_valid=0, bus_data=0, busy=0, full=0, and timeout=0 when present.
REQ-030 Reset asserted mid-XFER discards queued words and drops req in the same instant; no bus_valid follows.
REQ-031 Reset release is synchronized by the first rising clk edge after rst returns high; no pop or push occurs on that edge if push is low.

Configuration
REQ-032 Macro REQ_TIMEOUT_EN: when defined, a cycle counter runs in REQ and clears on leaving REQ.
REQ-033 With REQ_TIMEOUT_EN defined, if the counter reaches TIMEOUT without gnt, the block pulses timeout, drops req, enters HOLD, and keeps the FIFO intact.
REQ-034 Without REQ_TIMEOUT_EN, the block has no counter and no timeout port, and waits in REQ indefinitely.

Verification
REQ-035 Reset, push 0xA1, hold gnt=0 for 3 cycles then 1 -> req rises 1 cycle after push lands; 0xA1 appears with bus_valid one cycle after gnt is sampled; then HOLD and IDLE.
REQ-036 Push 0x11,0x22,0x33 with gnt held 1, BURST_LEN=2 -> 0x11 then 0x22 on bus, req low for one HOLD cycle, re-request, then 0x33.
REQ-037 Push 5 words into DEPTH=4 with gnt=0 -> full=1 and count=4; fifth word lost; drained order is words 1-4.
REQ-038 Grant in XFER, drop gnt after the first word -> only one word sent; FSM returns to REQ; remaining word sent on the next grant.
REQ-039 Assert rst=0 mid-XFER, then release -> outputs zero immediately; count=0; no stale word is ever emitted.
REQ-040 With REQ_TIMEOUT_EN and TIMEOUT=15, gnt tied 0 -> timeout pulses once after 15 REQ cycles, req low 1 cycle, count unchanged, re-request follows.

Source files
------------

// File: rtl/arb_requester.sv
// -----------------------------------------------------------------------------
// arb_requester
//
// Queues data words in a small FIFO and moves them onto a shared bus owned by a
// 3-way arbiter. The block raises req while it has work, and each granted cycle
// in XFER pops one word onto the bus. A grant delivers at most BURST_LEN words,
// after which req drops for one HOLD cycle so the arbiter can rotate to another
// requester. Every output comes straight from a flop.
//
// Parameters
//   DATA_W     width of each queued word
//   DEPTH      FIFO depth in words (power of two, >= 2)
//   BURST_LEN  maximum words sent per grant (>= 1)
//   TIMEOUT    grant-wait limit in REQ cycles (only used with REQ_TIMEOUT_EN)
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   push_i       enqueue push_data_i this cycle (dropped when full)
//   push_data_i  word to enqueue
//   full_o       FIFO holds DEPTH words
//   count_o      FIFO occupancy, 0..DEPTH
//   req_o        request line to the arbiter
//   gnt_i        grant from the arbiter
//   bus_valid_o  bus_data_o carries a word this cycle
//   bus_data_o   word on the shared bus; holds its last value when not valid
//   busy_o       FSM is not in IDLE
//   timeout_o    one-cycle pulse when a grant wait is abandoned
//                (port exists only with REQ_TIMEOUT_EN)
//
// Build option
//   REQ_TIMEOUT_EN  when defined, a counter bounds the time spent in REQ; on
//                   expiry the block pulses timeout_o, drops req and goes to
//                   HOLD with the FIFO intact. When undefined, the block waits
//                   in REQ indefinitely and has no counter or timeout port.
// -----------------------------------------------------------------------------
module arb_requester #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 4,
  parameter int BURST_LEN = 2,
  parameter int TIMEOUT   = 15
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic [DATA_W-1:0]      push_data_i,
  output logic                   full_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   req_o,
  input  logic                   gnt_i,
  output logic                   bus_valid_o,
  output logic [DATA_W-1:0]      bus_data_o,
  output logic                   busy_o
`ifdef REQ_TIMEOUT_EN
  ,
  output logic                   timeout_o
`endif
);

  // ---------------------------------------------------------------------------
  // Derived sizes and constants
  // ---------------------------------------------------------------------------
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int BEAT_W = $clog2(BURST_LEN + 1);

  localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(DEPTH);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_XFER = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;

  // Reject parameter sets the pointer arithmetic cannot handle.
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("arb_requester: DEPTH must be a power of two and at least 2");
  end
  if (BURST_LEN < 1 || TIMEOUT < 1) begin : g_bad_limits
    $error("arb_requester: BURST_LEN and TIMEOUT must be at least 1");
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [1:0]        state_q, state_d;
  logic [BEAT_W-1:0] beat_q, beat_d;

  logic              req_q, req_d;
  logic              busy_q, busy_d;
  logic              full_q, full_d;
  logic              bus_valid_q, bus_valid_d;
  logic [DATA_W-1:0] bus_data_q, bus_data_d;

`ifdef REQ_TIMEOUT_EN
  localparam int               TO_W    = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT - 1);

  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            timeout_q, timeout_d;
`endif

  logic push_ok;
  logic pop;

  // A push against a full FIFO is dropped even if a pop happens in the same
  // cycle; the decision uses the registered full flag only.
  assign push_ok = push_i && !full_q;

  // Only a granted XFER cycle pops. The count guard keeps a stray grant from
  // ever reading an empty FIFO.
  assign pop = (state_q == S_XFER) && gnt_i && (count_q != '0);

  // ---------------------------------------------------------------------------
  // FIFO bookkeeping and bus data path
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path through
    // the block can leave a value unassigned and infer a latch.
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    bus_data_d  = bus_data_q;
    bus_valid_d = pop;

    // DEPTH is a power of two, so natural overflow wraps the pointers.
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d   = rd_ptr_q + PTR_W'(1);
      bus_data_d = mem_q[rd_ptr_q];
    end

    // Simultaneous push and pop leave the occupancy unchanged.
    unique case ({push_ok, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    full_d = (count_d == FULL_CNT);
  end

  // ---------------------------------------------------------------------------
  // Request FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
`ifdef REQ_TIMEOUT_EN
    timeout_d = 1'b0;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          state_d = S_REQ;
        end
      end

      S_REQ: begin
        if (gnt_i) begin
          state_d = S_XFER;
          beat_d  = '0;
        end
`ifdef REQ_TIMEOUT_EN
        else if (to_cnt_q == TO_LAST) begin
          // Give up on this grant; the FIFO keeps its words and the HOLD
          // cycle lets the arbiter move on before we ask again.
          state_d   = S_HOLD;
          timeout_d = 1'b1;
        end
`endif
      end

      S_XFER: begin
        if (pop) begin
          beat_d = beat_q + BEAT_W'(1);
          // Burst ends on the BURST_LEN-th word or when this pop drains the
          // FIFO, whichever comes first.
          if (beat_d == LAST_BEAT || count_d == '0) begin
            state_d = S_HOLD;
          end
        end else begin
          // Grant withdrawn mid-burst: ask again if anything is left.
          state_d = (count_d != '0) ? S_REQ : S_IDLE;
        end
      end

      S_HOLD: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are decoded from the next state so they appear registered in
    // the same cycle the FSM occupies that state.
    req_d  = (state_d == S_REQ) || (state_d == S_XFER);
    busy_d = (state_d != S_IDLE);
  end

`ifdef REQ_TIMEOUT_EN
  // Counts consecutive REQ cycles; clears whenever the FSM leaves REQ.
  always_comb begin
    to_cnt_d = '0;
    if (state_q == S_REQ && state_d == S_REQ) begin
      to_cnt_d = to_cnt_q + TO_W'(1);
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state is updated with non-blocking assignments so every
    // flop samples the pre-edge values regardless of statement order.
    if (!rst) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      beat_q      <= '0;
      req_q       <= 1'b0;
      busy_q      <= 1'b0;
      full_q      <= 1'b0;
      bus_valid_q <= 1'b0;
      bus_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      beat_q      <= beat_d;
      req_q       <= req_d;
      busy_q      <= busy_d;
      full_q      <= full_d;
      bus_valid_q <= bus_valid_d;
      bus_data_q  <= bus_data_d;
    end
  end

`ifdef REQ_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      to_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      to_cnt_q  <= to_cnt_d;
      timeout_q <= timeout_d;
    end
  end
`endif

  // NOTE: the storage array has no reset; the cleared pointers and count make
  // any stale contents unreachable, and leaving it unreset lets it map to RAM.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign full_o      = full_q;
  assign count_o     = count_q;
  assign req_o       = req_q;
  assign bus_valid_o = bus_valid_q;
  assign bus_data_o  = bus_data_q;
  assign busy_o      = busy_q;
`ifdef REQ_TIMEOUT_EN
  assign timeout_o   = timeout_q;
`endif

endmodule

// File: tb/tb_arb_requester.sv
// -----------------------------------------------------------------------------
// tb_arb_requester
//
// Self-checking bench for arb_requester (DEPTH=4, BURST_LEN=2, TIMEOUT=15).
// A scoreboard queue receives each word the bench expects the FIFO to accept;
// every bus_valid cycle pops it and compares bus_data. Per-cycle control
// outputs are checked against a table of {inputs, expected outputs} records,
// followed by hand-written sequences for overflow, reset mid-burst, random
// traffic and (when REQ_TIMEOUT_EN is defined) the grant-wait timeout.
// -----------------------------------------------------------------------------
module tb_arb_requester;

  localparam int DATA_W    = 8;
  localparam int DEPTH     = 4;
  localparam int BURST_LEN = 2;
  localparam int TIMEOUT   = 15;

  logic              clk = 1'b0;
  logic              rst;
  logic              push_i;
  logic [DATA_W-1:0] push_data_i;
  logic              full_o;
  logic [2:0]        count_o;
  logic              req_o;
  logic              gnt_i;
  logic              bus_valid_o;
  logic [DATA_W-1:0] bus_data_o;
  logic              busy_o;
`ifdef REQ_TIMEOUT_EN
  logic              timeout_o;
`endif

  always #5 clk = ~clk;

  arb_requester #(
    .DATA_W    (DATA_W),
    .DEPTH     (DEPTH),
    .BURST_LEN (BURST_LEN),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push_i),
    .push_data_i (push_data_i),
    .full_o      (full_o),
    .count_o     (count_o),
    .req_o       (req_o),
    .gnt_i       (gnt_i),
    .bus_valid_o (bus_valid_o),
    .bus_data_o  (bus_data_o),
    .busy_o      (busy_o)
`ifdef REQ_TIMEOUT_EN
    ,
    .timeout_o   (timeout_o)
`endif
  );

  // ---------------------------------------------------------------------------
  // Bookkeeping
  // ---------------------------------------------------------------------------
  int                n_err   = 0;
  int                n_chk   = 0;
  int                n_words = 0;
  logic [DATA_W-1:0] sb [$];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // One clock of stimulus. Inputs change on the falling edge; outputs are
  // sampled 1 time unit after the rising edge. An accepted push goes into the
  // scoreboard (the FIFO is full exactly when the scoreboard holds DEPTH
  // words); any bus word is matched against the oldest expected entry.
  task automatic drive(input logic p, input logic [DATA_W-1:0] d,
                       input logic g);
    @(negedge clk);
    push_i      = p;
    push_data_i = d;
    gnt_i       = g;
    if (p && sb.size() < DEPTH) sb.push_back(d);
    @(posedge clk);
    #1;
    if (bus_valid_o) begin
      n_words++;
      if (sb.size() == 0) check("bus_spurious", 32'(bus_valid_o), 32'd0);
      else                check("bus_data", 32'(bus_data_o), 32'(sb.pop_front()));
    end
  endtask

  // Grant continuously until everything queued has left and the FSM is idle.
  task automatic drain(input string name);
    for (int i = 0; i < 40; i++) begin
      drive(1'b0, '0, 1'b1);
      if (sb.size() == 0 && !busy_o) break;
    end
    check(name, 32'(sb.size()), 32'd0);
    check({name, "_idle"}, 32'(busy_o), 32'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Per-cycle vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    logic              push;
    logic [DATA_W-1:0] data;
    logic              gnt;
    logic [6:0]        exp;  // {req, bus_valid, count[2:0], full, busy}
  } vec_t;

  vec_t vecs [$];

  function automatic vec_t mk(input logic p, input logic [DATA_W-1:0] d,
                              input logic g, input logic req, input logic bv,
                              input logic [2:0] cnt, input logic full,
                              input logic busy);
    vec_t v;
    v.push = p;
    v.data = d;
    v.gnt  = g;
    v.exp  = {req, bv, cnt, full, busy};
    return v;
  endfunction

  function automatic logic [6:0] observed();
    return {req_o, bus_valid_o, count_o, full_o, busy_o};
  endfunction

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int  words0;
    int  n_hi;
    bit  seen;

    //            push data   gnt  req bv cnt full busy
    // Single word, grant delayed three REQ cycles.
    vecs.push_back(mk(1, 8'hA1, 0,  0, 0, 3'd1, 0, 0)); // push lands, still IDLE
    vecs.push_back(mk(0, 8'h00, 0,  1, 0, 3'd1, 0, 1)); // req rises
    vecs.push_back(mk(0, 8'h00, 0,  1, 0, 3'd1, 0, 1));
    vecs.push_back(mk(0, 8'h00, 0,  1, 0, 3'd1, 0, 1));
    vecs.push_back(mk(0, 8'h00, 0,  1, 0, 3'd1, 0, 1));
    vecs.push_back(mk(0, 8'h00, 1,  1, 0, 3'd1, 0, 1)); // grant -> XFER
    vecs.push_back(mk(0, 8'h00, 1,  0, 1, 3'd0, 0, 1)); // A1 on bus, HOLD
    vecs.push_back(mk(0, 8'h00, 0,  0, 0, 3'd0, 0, 0)); // IDLE
    vecs.push_back(mk(0, 8'h00, 0,  0, 0, 3'd0, 0, 0));
    // Three words with grant held: burst of two, HOLD, re-request, last word.
    vecs.push_back(mk(1, 8'h11, 1,  0, 0, 3'd1, 0, 0));
    vecs.push_back(mk(1, 8'h22, 1,  1, 0, 3'd2, 0, 1));
    vecs.push_back(mk(1, 8'h33, 1,  1, 0, 3'd3, 0, 1)); // -> XFER
    vecs.push_back(mk(0, 8'h00, 1,  1, 1, 3'd2, 0, 1)); // 0x11
    vecs.push_back(mk(0, 8'h00, 1,  0, 1, 3'd1, 0, 1)); // 0x22, HOLD
    vecs.push_back(mk(0, 8'h00, 1,  0, 0, 3'd1, 0, 0)); // IDLE
    vecs.push_back(mk(0, 8'h00, 1,  1, 0, 3'd1, 0, 1)); // re-request
    vecs.push_back(mk(0, 8'h00, 1,  1, 0, 3'd1, 0, 1)); // -> XFER
    vecs.push_back(mk(0, 8'h00, 1,  0, 1, 3'd0, 0, 1)); // 0x33, HOLD
    vecs.push_back(mk(0, 8'h00, 0,  0, 0, 3'd0, 0, 0));
    // Grant withdrawn after the first word of a two-word burst.
    vecs.push_back(mk(1, 8'hD1, 0,  0, 0, 3'd1, 0, 0));
    vecs.push_back(mk(1, 8'hD2, 0,  1, 0, 3'd2, 0, 1));
    vecs.push_back(mk(0, 8'h00, 1,  1, 0, 3'd2, 0, 1)); // -> XFER
    vecs.push_back(mk(0, 8'h00, 1,  1, 1, 3'd1, 0, 1)); // 0xD1
    vecs.push_back(mk(0, 8'h00, 0,  1, 0, 3'd1, 0, 1)); // no pop, back to REQ
    vecs.push_back(mk(0, 8'h00, 0,  1, 0, 3'd1, 0, 1));
    vecs.push_back(mk(0, 8'h00, 1,  1, 0, 3'd1, 0, 1)); // REQ -> XFER, no pop yet
    vecs.push_back(mk(0, 8'h00, 1,  0, 1, 3'd0, 0, 1)); // 0xD2, HOLD
    vecs.push_back(mk(0, 8'h00, 0,  0, 0, 3'd0, 0, 0));

    // ---- reset state --------------------------------------------------------
    rst         = 1'b0;
    push_i      = 1'b0;
    push_data_i = '0;
    gnt_i       = 1'b0;
    #1;
    check("reset_outputs", 32'({observed(), bus_data_o}), 32'd0);
`ifdef REQ_TIMEOUT_EN
    check("reset_timeout", 32'(timeout_o), 32'd0);
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    // ---- table-driven vectors -----------------------------------------------
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].push, vecs[i].data, vecs[i].gnt);
      check($sformatf("vec%0d", i), 32'(observed()), 32'(vecs[i].exp));
    end
    check("table_words", 32'(n_words), 32'd6);

    // ---- overflow: five pushes into four slots, no grant --------------------
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 8'hC1 + 8'(i), 1'b0);
      if (i == 3) begin
        check("fill_count", 32'(count_o), 32'd4);
        check("fill_full",  32'(full_o),  32'd1);
      end
    end
    check("overflow_count", 32'(count_o), 32'd4);
    check("overflow_full",  32'(full_o),  32'd1);
    words0 = n_words;
    drain("overflow_drain");
    check("overflow_words", 32'(n_words - words0), 32'd4);
    check("overflow_empty", 32'({count_o, full_o}), 32'd0);

    // ---- reset asserted mid-burst -------------------------------------------
    drive(1'b1, 8'hE1, 1'b0);
    drive(1'b1, 8'hE2, 1'b0);
    drive(1'b1, 8'hE3, 1'b0);
    drive(1'b0, '0, 1'b1);                 // REQ -> XFER
    drive(1'b0, '0, 1'b1);                 // 0xE1 on the bus
    check("pre_reset_valid", 32'(bus_valid_o), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("midxfer_reset_outputs", 32'({observed(), bus_data_o}), 32'd0);
    sb.delete();
    @(posedge clk);
    #1;
    check("reset_held_outputs", 32'({observed(), bus_data_o}), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 6; i++) drive(1'b0, '0, 1'b1);
    check("post_reset_state", 32'(observed()), 32'd0);

    // ---- random traffic: occupancy and full tracked every cycle -------------
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
      check("rand_count", 32'(count_o), 32'(sb.size()));
      check("rand_full",  32'(full_o),  32'(sb.size() == DEPTH));
    end
    drain("rand_drain");

`ifdef REQ_TIMEOUT_EN
    // ---- grant-wait timeout -------------------------------------------------
    n_hi = 0;
    seen = 1'b0;
    drive(1'b1, 8'hF1, 1'b0);
    for (int i = 0; i < 40 && !seen; i++) begin
      drive(1'b0, '0, 1'b0);
      if (timeout_o)  seen = 1'b1;
      else if (req_o) n_hi++;
    end
    check("timeout_seen",       32'(seen),    32'd1);
    check("timeout_req_cycles", 32'(n_hi),    32'(TIMEOUT));
    check("timeout_req_low",    32'(req_o),   32'd0);
    check("timeout_count",      32'(count_o), 32'd1);
    drive(1'b0, '0, 1'b0);
    check("timeout_one_pulse",  32'(timeout_o), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 4 && !seen; i++) begin
      drive(1'b0, '0, 1'b0);
      if (req_o) seen = 1'b1;
    end
    check("timeout_rerequest",  32'(seen), 32'd1);
    drain("timeout_drain");
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
